mul_seq_32bit: RTL
==================

MUL_SEQ_32BIT -- requirements
Module: mul_seq_32bit

Interface
- REQ-001: Parameters: none; operand width fixed at 32 bits to match add_32bit.
- REQ-002: Single clock; reset is synchronous and active-low.
- REQ-003: CLK  input  1  rising-edge clock for all state.
- REQ-004: RST_N  input  1  synchronous active-low reset, sampled on CLK rising edge.
- REQ-005: START  input  1  request to begin a multiply; sampled every rising edge.
- REQ-006: A  input  32  unsigned multiplicand, sampled only on the edge that accepts START.
- REQ-007: B  input  32  unsigned multiplier, sampled only on the edge that accepts START.
- REQ-008: BUSY  output  1  high while an operation is in progress (state RUN).
- REQ-009: DONE  output  1  high while P holds a valid result (state DONE).
- REQ-010: P  output  64  unsigned product {high, low}.
- REQ-011: OVF  output  1  high when product does not fit in 32 bits, i.e. P[63:32] != 0; valid only while DONE=1.

Function
- REQ-012: Block SHALL instantiate exactly one add_32bit as its only adder; all accumulation SHALL pass through it with C_IN tied to 0.
- REQ-013: FSM SHALL have three states: IDLE, RUN, DONE; encoding free.
- REQ-014: IDLE: START=1 -> latch A into multiplicand register, load P <= {32'h0, B}, clear 5-bit iteration counter, go to RUN; START=0 -> stay.
- REQ-015: RUN, each edge: if P[0]=1, adder inputs X=P[63:32], Y=multiplicand; else Y=0; then P <= {C_OUT, Z, P[31:1]}; counter increments.
- REQ-016: RUN SHALL last exactly 32 edges; the edge on which counter==31 performs the last iteration and moves to DONE.
- REQ-017: Latency: START accepted on edge k -> BUSY=1 after edges k..k+31, DONE=1 and P final after edge k+32.
- REQ-018: START while in RUN SHALL be ignored: no operand capture, no restart, no effect on the result.
- REQ-019: DONE: P, OVF, DONE SHALL hold stable until START is sampled high; START=1 in DONE behaves as in IDLE (latch new operands, go to RUN, DONE drops after that edge).
- REQ-020: BUSY and DONE SHALL never be high simultaneously; both low in IDLE.
- REQ-021: Carry width: adder C_OUT SHALL be kept as P[63] after each shift; no product bit SHALL be lost for any 32x32 operands.
- REQ-022: A and B changing during RUN or DONE SHALL not affect P.
- REQ-023: P SHALL be an intermediate value in RUN; bench checks it only while DONE=1.

Reset
- REQ-024: RST_N=0 on a rising edge SHALL force IDLE, BUSY=0, DONE=0, OVF=0, P=64'h0, counter=0, regardless of state, including mid-RUN.
- REQ-025: START sampled on an edge with RST_N=0 SHALL be ignored; first acceptable START is on the first edge with RST_N=1.
- REQ-026: Operation aborted by reset SHALL produce no DONE pulse and no partial result.

Verification
- REQ-027: A=32'h0, B=32'h0, START 1 cycle -> after 32 edges DONE=1, P=64'h0, OVF=0; BUSY high for exactly 32 cycles.
- REQ-028: A=32'hFFFFFFFF, B=32'hFFFFFFFF -> P=64'hFFFFFFFE_00000001, OVF=1 (exercises C_OUT into P[63]).
- REQ-029: A=32'h7FFFFFFF, B=32'h2 -> P=64'h00000000_FFFFFFFE, OVF=0; A=32'h80000000, B=32'h2 -> P=64'h00000001_00000000, OVF=1.
- REQ-030: Start A=32'h3, B=32'hC; at RUN cycle 10 pulse START with A=B=32'hFFFFFFFF and change inputs -> result still P=64'h24, DONE at edge k+32.
- REQ-031: Start A=32'h7FFFFFFF, B=32'h7FFFFFFF; drop RST_N for one edge at RUN cycle 16 -> BUSY=0, DONE=0, P=0 next cycle, no DONE later; new START A=32'h1, B=32'hFFFFFFFF -> P=64'h00000000_FFFFFFFF.
- REQ-032: From DONE (P=64'h24), START with A=32'h80000000, B=32'h1 on the same edge -> DONE drops, BUSY rises, final P=64'h00000000_80000000, OVF=0.

Source files
------------

// File: rtl/mul_seq_32bit.sv
// Sequential 32x32 unsigned shift-and-add multiplier.
// One shared 32-bit adder performs every partial-product accumulation.
// The operation takes 32 iterations and yields a 64-bit product.
// The adder carry-out is shifted into P[63], so no product bit is lost.

// Plain ripple-style 32-bit adder with carry in/out.
module add_32bit (
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  input  logic        c_in_i,
  output logic [31:0] z_o,
  output logic        c_out_o
);

  logic [32:0] sum_s;

  // 33-bit sum so the carry-out falls out as the top bit.
  always_comb begin
    sum_s = {1'b0, x_i} + {1'b0, y_i} + {32'h0, c_in_i};
  end

  assign z_o     = sum_s[31:0];
  assign c_out_o = sum_s[32];

endmodule

module mul_seq_32bit (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] p_o,
  output logic        ovf_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [63:0] p_q, p_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [31:0] add_y_s;
  logic [31:0] add_z_s;
  logic        add_cout_s;

  // Partial-product select: add the multiplicand only when the current multiplier bit is set.
  always_comb begin
    if (p_q[0]) begin
      add_y_s = mcand_q;
    end else begin
      add_y_s = 32'h0;
    end
  end

  add_32bit u_add (
    .x_i     (p_q[63:32]),
    .y_i     (add_y_s),
    .c_in_i  (1'b0),
    .z_o     (add_z_s),
    .c_out_o (add_cout_s)
  );

  // Next-state and datapath update.
  // START is honoured only in IDLE/DONE; during RUN it is ignored.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          mcand_d = a_i;
          p_d     = {32'h0, b_i};
          cnt_d   = 5'd0;
          ovf_d   = 1'b0;
          state_d = ST_RUN;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        // Carry-out lands in P[63], so the upper half after the shift is {C_OUT, Z[31:1]}.
        p_d   = {add_cout_s, add_z_s, p_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = ST_DONE;
          ovf_d   = |{add_cout_s, add_z_s[31:1]};
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status flags are decoded from the next state so BUSY/DONE come straight from flops.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      ST_RUN:  busy_d = 1'b1;
      ST_DONE: done_d = 1'b1;
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      mcand_q <= 32'h0;
      p_q     <= 64'h0;
      cnt_q   <= 5'd0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign p_o    = p_q;
  assign ovf_o  = ovf_q;

endmodule
